// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared op codes, ALU mode constants and FSM state encoding
package alu_sequencer_pkg;
  localparam int W = 8;
  localparam int NW = 4;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_NOT  = 3'd7
  } op_t;
  typedef enum logic [3:0] {
    MODE_ADC  = 4'b0001,
    MODE_SBC  = 4'b0011,
    MODE_AND  = 4'b0101,
    MODE_OR   = 4'b0110,
    MODE_NOT  = 4'b0111,
    MODE_XOR  = 4'b1000,
    MODE_NAND = 4'b1001,
    MODE_NOR  = 4'b1010,
    MODE_IDLE = 4'b1111
  } mode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;
  function automatic mode_t mode_of(op_t op);
    return op == OP_ADD  ? MODE_ADC  :
           op == OP_SUB  ? MODE_SBC  :
           op == OP_AND  ? MODE_AND  :
           op == OP_OR   ? MODE_OR   :
           op == OP_XOR  ? MODE_XOR  :
           op == OP_NAND ? MODE_NAND :
           op == OP_NOR  ? MODE_NOR  : MODE_NOT;
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/result handshake plus the nibble bus to the external ALU
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [NW-1:0] alu_a;
  logic [NW-1:0] alu_b;
  logic [3:0]    alu_mode;
  logic          alu_carry_f;
  logic          alu_borrow_f;
  logic [NW-1:0] alu_c;
  logic [3:0]    alu_flags;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_cf;
  logic          res_zero;
  modport master (
    output op_valid, op_code, op_a, op_b, res_ready, alu_c, alu_flags,
    input  op_ready, alu_a, alu_b, alu_mode, alu_carry_f, alu_borrow_f,
           res_valid, res_data, res_cf, res_zero
  );
  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready, alu_c, alu_flags,
    output op_ready, alu_a, alu_b, alu_mode, alu_carry_f, alu_borrow_f,
           res_valid, res_data, res_cf, res_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs an 8-bit operation as two nibble passes through an external 4-bit ALU
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input logic clk,
  input logic rst,
  alu_sequencer_if.slave bus
);
  state_t state;
  op_t code;
  logic [W-1:0] a, b, data;
  logic cb, zlo, cf, zero, is_add, is_sub, hi, run, flag_cb;
  assign is_add = code == OP_ADD;
  assign is_sub = code == OP_SUB;
  assign hi = state == S_HI;
  assign run = state == S_LO || hi;
  assign flag_cb = is_add ? bus.alu_flags[0] : is_sub ? bus.alu_flags[1] : 1'b0;
  // Sequence IDLE -> LO -> HI -> DONE, assembling the result one nibble per pass
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      code <= OP_ADD;
      a <= '0;
      b <= '0;
      cb <= 1'b0;
      zlo <= 1'b0;
      data <= '0;
      cf <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.op_valid) begin
          state <= S_LO;
          code <= op_t'(bus.op_code);
          a <= bus.op_a;
          b <= bus.op_b;
        end
        S_LO: begin
          data[3:0] <= bus.alu_c;
          cb <= flag_cb;
          zlo <= bus.alu_flags[2];
          state <= S_HI;
        end
        S_HI: begin
          data[7:4] <= bus.alu_c;
          cf <= flag_cb;
          zero <= zlo & bus.alu_flags[2];
          state <= S_DONE;
        end
        default: if (bus.res_ready) state <= S_IDLE;
      endcase
    end
  end
  assign bus.op_ready = state == S_IDLE;
  assign bus.res_valid = state == S_DONE;
  assign bus.res_data = data;
  assign bus.res_cf = cf;
  assign bus.res_zero = zero;
  assign bus.alu_mode = run ? mode_of(code) : MODE_IDLE;
  assign bus.alu_a = run ? (hi ? a[7:4] : a[3:0]) : 4'h0;
  assign bus.alu_b = run && code != OP_NOT ? (hi ? b[7:4] : b[3:0]) : 4'h0;
  assign bus.alu_carry_f = hi && is_add && cb;
  assign bus.alu_borrow_f = hi && is_sub && cb;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural 4-bit ALU
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [4:0] s;
  logic [3:0] c;
  logic f0, f1;
  // Flags that the current mode does not define are driven 1 so stray sampling shows up
  always_comb begin
    s = 5'd0;
    c = 4'h0;
    f0 = 1'b1;
    f1 = 1'b1;
    case (bus.alu_mode)
      MODE_ADC: begin
        s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_carry_f};
        c = s[3:0];
        f0 = s[4];
      end
      MODE_SBC: begin
        s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'd0, bus.alu_borrow_f};
        c = s[3:0];
        f1 = s[4];
      end
      MODE_AND: c = bus.alu_a & bus.alu_b;
      MODE_OR: c = bus.alu_a | bus.alu_b;
      MODE_XOR: c = bus.alu_a ^ bus.alu_b;
      MODE_NAND: c = ~(bus.alu_a & bus.alu_b);
      MODE_NOR: c = ~(bus.alu_a | bus.alu_b);
      MODE_NOT: c = ~bus.alu_a;
      default: c = 4'h0;
    endcase
    bus.alu_c = c;
    bus.alu_flags = {bus.alu_a < bus.alu_b, c == 4'h0, f1, f0};
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_op(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b,
             output logic [7:0] d, output logic cf, output logic z,
             output logic [3:0] m, output logic [3:0] bl, output int lat);
    bus.op_valid = 1'b1;
    bus.op_code = code;
    bus.op_a = a;
    bus.op_b = b;
    tick();
    m = bus.alu_mode;
    bl = bus.alu_b;
    bus.op_valid = 1'b0;
    bus.op_a = 8'h00;
    bus.op_b = 8'h00;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      tick();
      lat++;
    end
    d = bus.res_data;
    cf = bus.res_cf;
    z = bus.res_zero;
  endtask

  logic [7:0] d;
  logic cf, z;
  logic [3:0] m, bl;
  int lat;

  task test_reset;
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b want 1", bus.op_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    checks++; if ({bus.res_data, bus.res_cf, bus.res_zero} !== 10'd0) begin errors++; $display("FAIL reset_res got %h/%b/%b want 00/0/0", bus.res_data, bus.res_cf, bus.res_zero); end
    checks++; if (bus.alu_mode !== 4'b1111) begin errors++; $display("FAIL reset_alu_mode got %b want 1111", bus.alu_mode); end
  endtask

  task test_add;
    do_op(3'd0, 8'h3A, 8'h27, d, cf, z, m, bl, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
    checks++; if ({d, cf, z} !== {8'h61, 1'b0, 1'b0}) begin errors++; $display("FAIL add_3a_27 got %h/%b/%b want 61/0/0", d, cf, z); end
    checks++; if (m !== 4'b0001) begin errors++; $display("FAIL add_mode got %b want 0001", m); end
    tick();
    checks++; if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_return_idle got %b/%b want 1/0", bus.op_ready, bus.res_valid); end
    do_op(3'd0, 8'hFF, 8'h01, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL add_ff_01 got %h/%b/%b want 00/1/1", d, cf, z); end
    tick();
  endtask

  task test_sub;
    do_op(3'd1, 8'h50, 8'h01, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'h4F, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_50_01 got %h/%b/%b want 4f/0/0", d, cf, z); end
    checks++; if (m !== 4'b0011) begin errors++; $display("FAIL sub_mode got %b want 0011", m); end
    tick();
    do_op(3'd1, 8'h00, 8'h01, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_00_01 got %h/%b/%b want ff/1/0", d, cf, z); end
    tick();
  endtask

  task test_logic;
    do_op(3'd4, 8'hF0, 8'hFF, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'h0F, 1'b0, 1'b0}) begin errors++; $display("FAIL xor_f0_ff got %h/%b/%b want 0f/0/0", d, cf, z); end
    checks++; if (m !== 4'b1000) begin errors++; $display("FAIL xor_mode got %b want 1000", m); end
    tick();
    do_op(3'd7, 8'hA5, 8'h3C, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'h5A, 1'b0, 1'b0}) begin errors++; $display("FAIL not_a5 got %h/%b/%b want 5a/0/0", d, cf, z); end
    checks++; if (m !== 4'b0111 || bl !== 4'h0) begin errors++; $display("FAIL not_mode_b got %b/%h want 0111/0", m, bl); end
    tick();
    do_op(3'd2, 8'h0F, 8'hF0, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'h00, 1'b0, 1'b1}) begin errors++; $display("FAIL and_0f_f0 got %h/%b/%b want 00/0/1", d, cf, z); end
    checks++; if (m !== 4'b0101) begin errors++; $display("FAIL and_mode got %b want 0101", m); end
    tick();
    do_op(3'd6, 8'h12, 8'h40, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'hAD, 1'b0, 1'b0}) begin errors++; $display("FAIL nor_12_40 got %h/%b/%b want ad/0/0", d, cf, z); end
    tick();
  endtask

  task test_stall;
    bus.res_ready = 1'b0;
    do_op(3'd0, 8'h3A, 8'h27, d, cf, z, m, bl, lat);
    for (int i = 0; i < 5; i++) begin
      bus.op_valid = 1'b1;
      bus.op_code = 3'd4;
      bus.op_a = 8'h11;
      bus.op_b = 8'h22;
      checks++; if ({bus.res_valid, bus.op_ready, bus.res_data, bus.res_cf, bus.res_zero} !== {1'b1, 1'b0, 8'h61, 1'b0, 1'b0}) begin errors++; $display("FAIL stall_hold[%0d] got v%b r%b %h/%b/%b want v1 r0 61/0/0", i, bus.res_valid, bus.op_ready, bus.res_data, bus.res_cf, bus.res_zero); end
      tick();
    end
    bus.op_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b/%b want 1/0", bus.op_ready, bus.res_valid); end
  endtask

  task test_reset_mid;
    int seen;
    bus.op_valid = 1'b1;
    bus.op_code = 3'd0;
    bus.op_a = 8'hFF;
    bus.op_b = 8'h01;
    tick();
    bus.op_valid = 1'b0;
    tick();
    checks++; if (bus.alu_carry_f !== 1'b1 || bus.alu_a !== 4'hF) begin errors++; $display("FAIL hi_carry_in got %b/%h want 1/f", bus.alu_carry_f, bus.alu_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.op_ready !== 1'b1 || bus.alu_mode !== 4'b1111) begin errors++; $display("FAIL mid_reset_idle got %b/%b want 1/1111", bus.op_ready, bus.alu_mode); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.res_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_result got %0d valid cycles want 0", seen); end
    do_op(3'd0, 8'h01, 8'h01, d, cf, z, m, bl, lat);
    checks++; if ({d, cf, z} !== {8'h02, 1'b0, 1'b0} || lat !== 3) begin errors++; $display("FAIL after_reset_add got %h/%b/%b lat %0d want 02/0/0 lat 3", d, cf, z, lat); end
    tick();
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_code = 3'd0;
    bus.op_a = 8'h00;
    bus.op_b = 8'h00;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
